ahb2wb: RTL
===========

AHB2WB -- requirements
Module: ahb2wb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of WAIT cycles without ack/err before an error response; 0 disables the timeout.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with ports listed below.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  async active-high reset.
- hsel  in  1  AHB slave select.
- haddr  in  32  AHB address.
- htrans  in  2  transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hburst  in  3  ignored.
- hwdata  in  32  write data, data phase.
- hready_in  in  1  bus-wide HREADY.
- hready_out  out  1  slave ready.
- hresp  out  2  OKAY 00, ERROR 01.
- hrdata  out  32  read data.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_sel_o  out  4  byte lanes.
- wb_we_o  out  1  Wishbone write.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.

Function
REQ-003 SHALL implement states IDLE, SETUP, WAIT, DONE, ERR1, ERR2; hready_out=1 in IDLE, DONE and ERR2, and 0 elsewhere.
REQ-004 SHALL accept a transfer when hsel & hready_in & htrans[1] & hready_out; it SHALL register haddr, hwrite and hsize, then go to SETUP; SEQ is treated as NONSEQ.
REQ-005 SHALL treat IDLE/BUSY, or hsel=0, in an accepting state as no transfer; the next state is IDLE with OKAY and zero wait.
REQ-006 SHALL, in SETUP, register hwdata into wb_dat_o (writes), drive wb_adr_o={haddr[31:2],2'b00}, drive wb_sel_o and wb_we_o, and set wb_cyc_o=wb_stb_o=1 at the end of the cycle, then go to WAIT.
REQ-007 SHALL decode wb_sel_o little-endian: byte 0001<<haddr[1:0]; halfword 0011<<{haddr[1],1'b0}; word 1111.
REQ-008 SHALL handle hsize>=011, a halfword with haddr[0]=1, or a word with haddr[1:0]!=0 by going SETUP->ERR1 with no Wishbone cycle.
REQ-009 SHALL, in WAIT, on wb_ack_i: deassert cyc/stb next edge, register hrdata<=wb_dat_i (reads only; writes keep hrdata), and go to DONE with OKAY.
REQ-010 SHALL give wb_err_i in WAIT priority over a simultaneous wb_ack_i: deassert cyc/stb and go to ERR1.
REQ-011 SHALL hold an 8-bit-minimum WAIT counter, cleared on WAIT entry; when it reaches TIMEOUT (TIMEOUT!=0) with no ack/err, it SHALL deassert cyc/stb and go to ERR1.
REQ-012 SHALL drive hresp=ERROR in ERR1 (hready_out=0) and in ERR2 (hready_out=1); ERR1 goes to ERR2 unconditionally.
REQ-013 SHALL, in DONE/ERR2, go to SETUP if a new transfer is accepted, else to IDLE.
REQ-014 SHALL have a minimum latency of 2 wait states: address phase at edge N, hready_out low in cycles N+1..N+2, DONE in N+3 for ack in the first WAIT cycle.
REQ-015 SHALL hold wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o stable while wb_cyc_o=1.

Reset
REQ-016 SHALL, on rst_i asserted, immediately force state=IDLE, hready_out=1, hresp=00, hrdata=0, wb_cyc_o=wb_stb_o=wb_we_o=0, and wb_adr_o=wb_dat_o=0, wb_sel_o=0.
REQ-017 SHALL abort an in-flight Wishbone cycle when reset asserts mid-transfer, without a further ack being required.

Structure
REQ-018 SHALL place the state enum, HTRANS/HRESP/HSIZE constants and the default TIMEOUT in shared package ahb2wb_pkg.
REQ-019 SHALL have one combinational sub-module ahb2wb_sel_dec, which performs the hsize/haddr to wb_sel_o decode plus the alignment-error flag.

Verification
REQ-020 SHALL cover a word write: 0x40 with data 0xDEADBEEF, ack on the first WAIT cycle -> wb_sel_o=1111, wb_dat_o=0xDEADBEEF, hready_out low 2 cycles, OKAY.
REQ-021 SHALL cover a byte read: 0x43 with wb_dat_i=0x12345678 and ack after 3 WAIT cycles -> wb_sel_o=1000, hrdata=0x12345678, hready_out low 5 cycles.
REQ-022 SHALL cover a halfword at 0x41 -> no wb_cyc_o, hresp=01 for 2 cycles, hready_out pattern 0,1.
REQ-023 SHALL cover wb_err_i and wb_ack_i asserted together -> ERROR two-cycle response, hrdata unchanged.
REQ-024 SHALL cover TIMEOUT=4 with no ack -> cyc/stb drop after 4 WAIT cycles, then ERROR response.
REQ-025 SHALL cover back-to-back NONSEQ during DONE, plus rst_i asserted in WAIT -> second transfer starts SETUP next cycle; reset immediately clears cyc/stb.

Source files
------------

// File: rtl/ahb2wb_pkg.sv
// Shared types and constants for the AHB-to-Wishbone bridge.
package ahb2wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ahb2wb_sel_dec.sv
// Little-endian byte-lane decode of hsize/haddr[1:0] with misalignment flag.
module ahb2wb_sel_dec
  import ahb2wb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] sel_o,
  output logic       err_o
);

  always_comb begin
    sel_o = '0;
    err_o = 1'b0;
    case (size_i)
      HSIZE_BYTE: sel_o = 4'b0001 << addr_i;
      HSIZE_HALF: begin
        if (addr_i[0]) err_o = 1'b1;
        else           sel_o = 4'b0011 << {addr_i[1], 1'b0};
      end
      HSIZE_WORD: begin
        if (addr_i != 2'b00) err_o = 1'b1;
        else                 sel_o = '1;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb2wb.sv
// AHB-Lite slave to Wishbone master bridge, one outstanding transfer,
// two-cycle ERROR response on misalignment, wb_err_i or WAIT timeout.
module ahb2wb
  import ahb2wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_e        state_q;
  logic [31:0]   addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hrdata_q;
  logic [31:0]   wb_adr_q;
  logic [31:0]   wb_dat_q;
  logic [3:0]    wb_sel_q;
  logic          wb_we_q;
  logic          wb_cyc_q;

  logic [3:0]    dec_sel;
  logic          dec_err;
  logic          accept;

  // hburst and htrans[0] carry no meaning for this slave.
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  ahb2wb_sel_dec u_sel_dec (
    .size_i (size_q),
    .addr_i (addr_q[1:0]),
    .sel_o  (dec_sel),
    .err_o  (dec_err)
  );

  assign hready_out = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign hresp      = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign accept     = hsel & hready_in & htrans[1] & hready_out;

  assign hrdata   = hrdata_q;
  assign wb_adr_o = wb_adr_q;
  assign wb_dat_o = wb_dat_q;
  assign wb_sel_o = wb_sel_q;
  assign wb_we_o  = wb_we_q;
  assign wb_cyc_o = wb_cyc_q;
  assign wb_stb_o = wb_cyc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      cnt_q    <= '0;
      hrdata_q <= '0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_sel_q <= '0;
      wb_we_q  <= 1'b0;
      wb_cyc_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          if (accept) begin
            addr_q  <= haddr;
            write_q <= hwrite;
            size_q  <= hsize;
            state_q <= ST_SETUP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (dec_err) begin
            state_q <= ST_ERR1;
          end else begin
            wb_adr_q <= {addr_q[31:2], 2'b00};
            wb_sel_q <= dec_sel;
            wb_we_q  <= write_q;
            if (write_q) wb_dat_q <= hwdata;
            wb_cyc_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Error outranks ack; timeout only fires when neither is present.
          if (wb_err_i) begin
            wb_cyc_q <= 1'b0;
            state_q  <= ST_ERR1;
          end else if (wb_ack_i) begin
            wb_cyc_q <= 1'b0;
            if (!wb_we_q) hrdata_q <= wb_dat_i;
            state_q  <= ST_DONE;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            wb_cyc_q <= 1'b0;
            state_q  <= ST_ERR1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_ERR1: state_q <= ST_ERR2;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
